pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Frame-rate game controller for the Pong display path. Once per video frame it advances both paddles from button inputs, moves the ball, resolves wall and paddle bounces and misses, and keeps score. It sequences serve, play, point-pause and game-over phases. Its position outputs feed the pixel draw logic directly and are stable for the whole active frame.

## Interface
Parameters:
- BALL_SIZE, 11'd20: ball edge length in pixels
- PAD_HEIGHT, 11'd100: paddle height
- PAD_WIDTH, 11'd10: paddle width
- PAD_OFFS, 11'd35: paddle distance from screen edge
- H_RES, 11'd1280: horizontal resolution
- V_RES, 11'd800: vertical resolution
- BALL_SPEED, 11'd4: ball step per frame on each axis
- PAD_SPEED, 11'd6: paddle step per frame
- WIN_SCORE, 4'd9: points that end the game
- PAUSE_FRAMES, 8'd60: frames held after a point

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- frame_tick  in  1  one-cycle pulse at start of vertical blank; never two in consecutive cycles
- btn_l_up, btn_l_dn, btn_r_up, btn_r_dn  in  1 each  synchronized, debounced paddle buttons, level
- serve  in  1  one-cycle pulse, start play or restart after game over
- ball_x, ball_y  out  11  ball top-left corner
- padl_y, padr_y  out  11  paddle top edges
- score_l, score_r  out  4  scores
- game_over  out  1  high in OVER
- state  out  2  current state, IDLE=0, PLAY=1, POINT=2, OVER=3

## Operation
- Reset values: ball_x=(H_RES-BALL_SIZE)/2=630, ball_y=(V_RES-BALL_SIZE)/2=390, padl_y=padr_y=(V_RES-PAD_HEIGHT)/2=350, scores 0, game_over 0, state IDLE, velocity +x/+y, pause counter 0.
- Paddles update on each frame_tick in IDLE, PLAY and POINT. They are frozen in OVER.
  - Up only: subtract PAD_SPEED, clamped at 0.
  - Down only: add PAD_SPEED, clamped at V_RES-PAD_HEIGHT.
  - Both or neither pressed: hold.
- IDLE: ball held at center.
  - serve: go to PLAY with vx=+, vy=+.
  - The ball does not move on the cycle of the transition, even if frame_tick coincides.
- PLAY, on each frame_tick, ball y axis:
  - Next y = y ± BALL_SPEED.
  - Moving up with y < BALL_SPEED: y=0 and vy flips to +.
  - Moving down with y+BALL_SIZE+BALL_SPEED > V_RES: y=V_RES-BALL_SIZE and vy flips to −.
- PLAY, left paddle, when moving left:
  - Hit condition: x ≥ PAD_OFFS+PAD_WIDTH, x−BALL_SPEED < PAD_OFFS+PAD_WIDTH, and vertical overlap (ball_y+BALL_SIZE > padl_y and ball_y < padl_y+PAD_HEIGHT). On a hit: x=PAD_OFFS+PAD_WIDTH=45 and vx flips to +.
  - Miss: otherwise, if x < BALL_SPEED, score_r increments.
- PLAY, right paddle: mirror of the left paddle.
  - Paddle face RX=H_RES-PAD_OFFS-PAD_WIDTH-1=1234. On a hit, x=RX-BALL_SIZE=1214 and vx flips to −.
  - Miss: x+BALL_SIZE+BALL_SPEED > H_RES gives score_l+1.
- Point scored:
  - If the new score equals WIN_SCORE: go to OVER, game_over=1.
  - Otherwise: go to POINT, ball recentered, pause counter loaded with PAUSE_FRAMES.
- POINT: counter decrements per frame_tick. Leaving 1→0 enters PLAY with vx toward the side that lost the point and vy=+. serve is ignored.
- OVER: ball at center. serve clears both scores and game_over and goes to IDLE. Paddles keep their positions.
- Arithmetic is done in 12 bits so underflow is detected before clamping. Outputs are 11-bit unsigned. Scores never exceed WIN_SCORE.

## Timing
- All outputs are registered and change only on the clk edge where frame_tick=1 or serve=1. They are valid the next cycle, so latency is 1 cycle.
- Collision tests use current-frame registers. Ball and paddles update in the same edge, and the ball uses the pre-update paddle positions.
- Wall bounce and paddle hit in the same tick: both axes are resolved independently.
- rst mid-frame forces reset values immediately, with no clock needed.

## Structure
- Shared package pong_pkg: state encoding, default geometry constants, and a center-position function. drawcon-side users import the same package.
- Sub-module pong_paddle_ctrl (clamp and step logic) is instantiated twice, for left and right.
- Top level holds the FSM, ball datapath, scores and pause counter.

## Test plan
- Reset: outputs 630/390/350/350, scores 0, state=0, game_over=0. Buttons held with no tick produce no change.
- btn_l_up held with padl_y=350: after 59 ticks padl_y=0, and stays 0 on tick 60. Both left buttons pressed: no movement.
- serve, then 1 tick: ball at 634/394, state=1. Run on until the bottom wall: ball_y=780, then it decreases by 4 per tick.
- Left paddle aligned with the ball's y and ball moving left: ball_x=45 on the hit tick, 49 on the next.
- Left paddle parked at y=0 while the ball passes low: score_r=1, state=2, ball at 630/390. After 60 ticks state=1 and ball_x=626.
- score_r reaches 9: state=3, game_over=1, paddles frozen. serve: scores 0, state=0. rst asserted mid-play restores all reset values asynchronously.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong definitions: state encoding, default geometry and a centering helper.
// The draw path imports this package too, so geometry stays consistent on both sides.
package pong_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_PLAY  = 2'd1;
  localparam state_t ST_POINT = 2'd2;
  localparam state_t ST_OVER  = 2'd3;

  localparam logic [10:0] DEF_BALL_SIZE  = 11'd20;
  localparam logic [10:0] DEF_PAD_HEIGHT = 11'd100;
  localparam logic [10:0] DEF_PAD_WIDTH  = 11'd10;
  localparam logic [10:0] DEF_PAD_OFFS   = 11'd35;
  localparam logic [10:0] DEF_H_RES      = 11'd1280;
  localparam logic [10:0] DEF_V_RES      = 11'd800;
  localparam logic [10:0] DEF_BALL_SPEED = 11'd4;
  localparam logic [10:0] DEF_PAD_SPEED  = 11'd6;
  localparam logic [3:0]  DEF_WIN_SCORE  = 4'd9;
  localparam logic [7:0]  DEF_PAUSE_FRAMES = 8'd60;

  // Top-left coordinate that centers an object of length 'size' within 'res'.
  function automatic logic [10:0] center(input logic [10:0] res, input logic [10:0] size);
    logic [10:0] diff;
    diff = res - size;
    return {1'b0, diff[10:1]};
  endfunction

endpackage

// File: rtl/pong_paddle_ctrl.sv
// One paddle's vertical position: steps by PAD_SPEED per enabled frame, clamped to the screen.
// Used once per side by pong_game_ctrl.
module pong_paddle_ctrl
  import pong_pkg::*;
#(
  parameter logic [10:0] V_RES      = DEF_V_RES,
  parameter logic [10:0] PAD_HEIGHT = DEF_PAD_HEIGHT,
  parameter logic [10:0] PAD_SPEED  = DEF_PAD_SPEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic        up,
  input  logic        dn,
  output logic [10:0] pos
);

  localparam logic [11:0] MAX_Y = {1'b0, V_RES - PAD_HEIGHT};
  localparam logic [11:0] SPD   = {1'b0, PAD_SPEED};

  logic [11:0] cur;
  logic [11:0] dec;
  logic [11:0] inc;
  logic [11:0] nxt;

  assign cur = {1'b0, pos};
  assign dec = cur - SPD;
  assign inc = cur + SPD;

  // Bit 11 of the 12-bit difference flags an upward step past the top edge.
  always_comb begin
    nxt = cur;
    if (up && !dn) begin
      nxt = dec[11] ? 12'd0 : dec;
    end else if (dn && !up) begin
      nxt = (inc > MAX_Y) ? MAX_Y : inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= center(V_RES, PAD_HEIGHT);
    end else if (step) begin
      pos <= nxt[10:0];
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-rate Pong controller: phase FSM, ball motion with wall/paddle bounces, scoring
// and post-point pause. Outputs are registered and feed the pixel draw logic directly.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter logic [10:0] BALL_SIZE    = DEF_BALL_SIZE,
  parameter logic [10:0] PAD_HEIGHT   = DEF_PAD_HEIGHT,
  parameter logic [10:0] PAD_WIDTH    = DEF_PAD_WIDTH,
  parameter logic [10:0] PAD_OFFS     = DEF_PAD_OFFS,
  parameter logic [10:0] H_RES        = DEF_H_RES,
  parameter logic [10:0] V_RES        = DEF_V_RES,
  parameter logic [10:0] BALL_SPEED   = DEF_BALL_SPEED,
  parameter logic [10:0] PAD_SPEED    = DEF_PAD_SPEED,
  parameter logic [3:0]  WIN_SCORE    = DEF_WIN_SCORE,
  parameter logic [7:0]  PAUSE_FRAMES = DEF_PAUSE_FRAMES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn_l_up,
  input  logic        btn_l_dn,
  input  logic        btn_r_up,
  input  logic        btn_r_dn,
  input  logic        serve,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic [10:0] padl_y,
  output logic [10:0] padr_y,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic        game_over,
  output logic [1:0]  state
);

  localparam logic [10:0] CX = center(H_RES, BALL_SIZE);
  localparam logic [10:0] CY = center(V_RES, BALL_SIZE);

  localparam logic [11:0] SPD   = {1'b0, BALL_SPEED};
  localparam logic [11:0] SZ    = {1'b0, BALL_SIZE};
  localparam logic [11:0] PH    = {1'b0, PAD_HEIGHT};
  localparam logic [11:0] HR    = {1'b0, H_RES};
  localparam logic [11:0] VR    = {1'b0, V_RES};
  localparam logic [11:0] Y_MAX = {1'b0, V_RES - BALL_SIZE};
  localparam logic [11:0] LX    = {1'b0, PAD_OFFS + PAD_WIDTH};
  localparam logic [11:0] RXH   = {1'b0, H_RES - PAD_OFFS - PAD_WIDTH - 11'd1 - BALL_SIZE};

  logic        vx;
  logic        vy;
  logic [7:0]  pause_cnt;
  logic        pad_step;

  logic [11:0] bx;
  logic [11:0] by;
  logic [11:0] pl;
  logic [11:0] pr;
  logic [11:0] nx;
  logic [11:0] ny;
  logic        nvx;
  logic        nvy;
  logic        ov_l;
  logic        ov_r;
  logic        hit_l;
  logic        hit_r;
  logic        miss_l;
  logic        miss_r;
  logic [3:0]  sl_inc;
  logic [3:0]  sr_inc;
  logic        win;

  assign pad_step = frame_tick && (state != ST_OVER);

  pong_paddle_ctrl #(
    .V_RES      (V_RES),
    .PAD_HEIGHT (PAD_HEIGHT),
    .PAD_SPEED  (PAD_SPEED)
  ) u_pad_l (
    .clk  (clk),
    .rst  (rst),
    .step (pad_step),
    .up   (btn_l_up),
    .dn   (btn_l_dn),
    .pos  (padl_y)
  );

  pong_paddle_ctrl #(
    .V_RES      (V_RES),
    .PAD_HEIGHT (PAD_HEIGHT),
    .PAD_SPEED  (PAD_SPEED)
  ) u_pad_r (
    .clk  (clk),
    .rst  (rst),
    .step (pad_step),
    .up   (btn_r_up),
    .dn   (btn_r_dn),
    .pos  (padr_y)
  );

  assign bx = {1'b0, ball_x};
  assign by = {1'b0, ball_y};
  assign pl = {1'b0, padl_y};
  assign pr = {1'b0, padr_y};

  // Collisions look at the paddle positions as they stood during this frame.
  assign ov_l   = (by + SZ > pl) && (by < pl + PH);
  assign ov_r   = (by + SZ > pr) && (by < pr + PH);
  assign hit_l  = !vx && (bx >= LX) && (bx - SPD < LX) && ov_l;
  assign hit_r  = vx && (bx <= RXH) && (bx + SPD > RXH) && ov_r;
  assign miss_l = !vx && !hit_l && (bx < SPD);
  assign miss_r = vx && !hit_r && (bx + SZ + SPD > HR);

  assign sl_inc = score_l + 4'd1;
  assign sr_inc = score_r + 4'd1;
  assign win    = miss_l ? (sr_inc == WIN_SCORE) : (sl_inc == WIN_SCORE);

  always_comb begin
    nx  = vx ? (bx + SPD) : (bx - SPD);
    nvx = vx;
    if (hit_l) begin
      nx  = LX;
      nvx = 1'b1;
    end else if (hit_r) begin
      nx  = RXH;
      nvx = 1'b0;
    end
    ny  = vy ? (by + SPD) : (by - SPD);
    nvy = vy;
    if (vy && (by + SZ + SPD > VR)) begin
      ny  = Y_MAX;
      nvy = 1'b0;
    end else if (!vy && (by < SPD)) begin
      ny  = 12'd0;
      nvy = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ball_x    <= CX;
      ball_y    <= CY;
      vx        <= 1'b1;
      vy        <= 1'b1;
      score_l   <= 4'd0;
      score_r   <= 4'd0;
      game_over <= 1'b0;
      state     <= ST_IDLE;
      pause_cnt <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (serve) begin
            state <= ST_PLAY;
            vx    <= 1'b1;
            vy    <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (frame_tick) begin
            if (miss_l || miss_r) begin
              if (miss_l) score_r <= sr_inc;
              else        score_l <= sl_inc;
              ball_x <= CX;
              ball_y <= CY;
              // The loser receives the next serve.
              vx     <= miss_r;
              vy     <= 1'b1;
              if (win) begin
                state     <= ST_OVER;
                game_over <= 1'b1;
              end else begin
                state     <= ST_POINT;
                pause_cnt <= PAUSE_FRAMES;
              end
            end else begin
              ball_x <= nx[10:0];
              ball_y <= ny[10:0];
              vx     <= nvx;
              vy     <= nvy;
            end
          end
        end
        ST_POINT: begin
          if (frame_tick) begin
            if (pause_cnt <= 8'd1) begin
              pause_cnt <= 8'd0;
              state     <= ST_PLAY;
              ball_x    <= vx ? (CX + BALL_SPEED) : (CX - BALL_SPEED);
              ball_y    <= CY + BALL_SPEED;
              vy        <= 1'b1;
            end else begin
              pause_cnt <= pause_cnt - 8'd1;
            end
          end
        end
        default: begin
          if (serve) begin
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            game_over <= 1'b0;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomized and scripted bench for pong_game_ctrl, checked every cycle against a
// game-level model that tracks positions, signed velocities and scores as plain integers.
module tb_pong_game_ctrl;

  localparam int BALL = 20;
  localparam int PADH = 100;
  localparam int HRES = 1280;
  localparam int VRES = 800;
  localparam int BSPD = 4;
  localparam int PSPD = 6;
  localparam int FACE_L = 35 + 10;
  localparam int FACE_R = HRES - 35 - 10 - 1;
  localparam int CX = (HRES - BALL) / 2;
  localparam int CY = (VRES - BALL) / 2;
  localparam int PC = (VRES - PADH) / 2;

  typedef struct {
    int bx, by, dx, dy, pl, pr, sl, sr, st, go, pause;
  } game_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick, btn_l_up, btn_l_dn, btn_r_up, btn_r_dn, serve;
  logic [10:0] ball_x, ball_y, padl_y, padr_y;
  logic [3:0]  score_l, score_r;
  logic        game_over;
  logic [1:0]  state;

  game_t m;
  int vectors = 0;
  int errors = 0;

  pong_game_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .btn_l_up   (btn_l_up),
    .btn_l_dn   (btn_l_dn),
    .btn_r_up   (btn_r_up),
    .btn_r_dn   (btn_r_dn),
    .serve      (serve),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .padl_y     (padl_y),
    .padr_y     (padr_y),
    .score_l    (score_l),
    .score_r    (score_r),
    .game_over  (game_over),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("ball_x", int'(ball_x), m.bx);
    checkOutput("ball_y", int'(ball_y), m.by);
    checkOutput("padl_y", int'(padl_y), m.pl);
    checkOutput("padr_y", int'(padr_y), m.pr);
    checkOutput("score_l", int'(score_l), m.sl);
    checkOutput("score_r", int'(score_r), m.sr);
    checkOutput("game_over", int'(game_over), m.go);
    checkOutput("state", int'(state), m.st);
  endtask

  function automatic game_t modelReset();
    game_t g;
    g = '{bx: CX, by: CY, dx: BSPD, dy: BSPD, pl: PC, pr: PC,
          sl: 0, sr: 0, st: 0, go: 0, pause: 0};
    return g;
  endfunction

  function automatic int padMove(int p, bit u, bit d);
    if (u && !d) return (p - PSPD < 0) ? 0 : p - PSPD;
    if (d && !u) return (p + PSPD > VRES - PADH) ? VRES - PADH : p + PSPD;
    return p;
  endfunction

  function automatic bit overlaps(int y, int p);
    return (y + BALL > p) && (y < p + PADH);
  endfunction

  // One clock of the game rules, applied to the state as it stood before the edge.
  task automatic modelStep(input bit tick, input bit srv, input bit lu, input bit ld,
                           input bit ru, input bit rd);
    game_t n;
    int nx, ny, scorer;
    n = m;
    if (tick && m.st != 3) begin
      n.pl = padMove(m.pl, lu, ld);
      n.pr = padMove(m.pr, ru, rd);
    end
    case (m.st)
      0: if (srv) begin n.st = 1; n.dx = BSPD; n.dy = BSPD; end
      1: if (tick) begin
        ny = m.by + m.dy;
        if (ny < 0) begin ny = 0; n.dy = BSPD; end
        else if (ny > VRES - BALL) begin ny = VRES - BALL; n.dy = -BSPD; end
        nx = m.bx + m.dx;
        scorer = 0;
        if (m.dx < 0) begin
          if (m.bx >= FACE_L && nx < FACE_L && overlaps(m.by, m.pl)) begin
            nx = FACE_L; n.dx = BSPD;
          end else if (nx < 0) scorer = 2;
        end else begin
          if (m.bx + BALL <= FACE_R && nx + BALL > FACE_R && overlaps(m.by, m.pr)) begin
            nx = FACE_R - BALL; n.dx = -BSPD;
          end else if (nx + BALL > HRES) scorer = 1;
        end
        n.bx = nx;
        n.by = ny;
        if (scorer != 0) begin
          if (scorer == 1) n.sl++; else n.sr++;
          n.bx = CX; n.by = CY; n.dy = BSPD;
          n.dx = (scorer == 1) ? BSPD : -BSPD;
          if (n.sl == 9 || n.sr == 9) begin n.st = 3; n.go = 1; end
          else begin n.st = 2; n.pause = 60; end
        end
      end
      2: if (tick) begin
        n.pause = m.pause - 1;
        if (n.pause == 0) begin
          n.st = 1; n.bx = CX + m.dx; n.by = CY + BSPD; n.dy = BSPD;
        end
      end
      default: if (srv) begin n.sl = 0; n.sr = 0; n.go = 0; n.st = 0; end
    endcase
    m = n;
  endtask

  task automatic applyStimulus(input bit tick, input bit srv, input bit lu, input bit ld,
                               input bit ru, input bit rd);
    frame_tick = tick; serve = srv;
    btn_l_up = lu; btn_l_dn = ld; btn_r_up = ru; btn_r_dn = rd;
    @(posedge clk);
    #1;
    modelStep(tick, srv, lu, ld, ru, rd);
    frame_tick = 1'b0; serve = 1'b0;
    checkAll();
  endtask

  task automatic frameStep(input bit lu, input bit ld, input bit ru, input bit rd);
    applyStimulus(1'b1, 1'b0, lu, ld, ru, rd);
    applyStimulus(1'b0, 1'b0, lu, ld, ru, rd);
  endtask

  // Steer a paddle so its middle follows the ball's middle.
  task automatic trackPad(input int p, output bit u, output bit d);
    int target;
    target = m.by + BALL / 2 - PADH / 2;
    u = (p > target + 3);
    d = (p < target - 3);
  endtask

  task automatic asyncReset();
    #2 rst = 1'b1;
    #1;
    m = modelReset();
    checkAll();
    checkOutput("rst_ball_x", int'(ball_x), 630);
    checkOutput("rst_padl_y", int'(padl_y), 350);
    #2 rst = 1'b0;
  endtask

  initial begin
    bit lu, ld, ru, rd;
    int budget;
    int frozen_l, frozen_r;

    rst = 1'b1; frame_tick = 1'b0; serve = 1'b0;
    btn_l_up = 1'b0; btn_l_dn = 1'b0; btn_r_up = 1'b0; btn_r_dn = 1'b0;
    m = modelReset();
    #1;
    checkAll();
    checkOutput("reset_ball_y", int'(ball_y), 390);
    #6 rst = 1'b0;

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("no_tick_padl", int'(padl_y), 350);

    frameStep(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("both_btn_padl", int'(padl_y), 350);

    for (int i = 0; i < 58; i++) frameStep(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("padl_after58", int'(padl_y), 2);
    frameStep(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("padl_clamp_top", int'(padl_y), 0);
    checkOutput("padr_clamp_bot", int'(padr_y), 700);
    frameStep(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("padl_stay_top", int'(padl_y), 0);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("serve_state", int'(state), 1);
    checkOutput("serve_no_move", int'(ball_x), 630);
    frameStep(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("first_x", int'(ball_x), 634);
    checkOutput("first_y", int'(ball_y), 394);
    for (int i = 0; i < 97; i++) frameStep(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("bottom_wall_y", int'(ball_y), 780);
    frameStep(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("after_wall_y", int'(ball_y), 776);

    budget = 0;
    while (!(m.dx > 0 && m.bx == FACE_L) && budget < 1000) begin
      trackPad(m.pl, lu, ld);
      trackPad(m.pr, ru, rd);
      frameStep(lu, ld, ru, rd);
      budget++;
    end
    checkOutput("left_hit_x", int'(ball_x), 45);
    frameStep(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("left_hit_next_x", int'(ball_x), 49);

    asyncReset();
    checkOutput("rst_state", int'(state), 0);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    budget = 0;
    while (m.st != 2 && budget < 1500) begin
      trackPad(m.pr, ru, rd);
      frameStep(1'b1, 1'b0, ru, rd);
      budget++;
    end
    checkOutput("point_state", int'(state), 2);
    checkOutput("point_score_r", int'(score_r), 1);
    checkOutput("point_ball_x", int'(ball_x), 630);
    checkOutput("point_ball_y", int'(ball_y), 390);
    for (int i = 0; i < 60; i++) frameStep(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("resume_state", int'(state), 1);
    checkOutput("resume_ball_x", int'(ball_x), 626);

    budget = 0;
    while (m.st != 3 && budget < 6000) begin
      trackPad(m.pr, ru, rd);
      frameStep(1'b1, 1'b0, ru, rd);
      budget++;
    end
    checkOutput("over_state", int'(state), 3);
    checkOutput("over_flag", int'(game_over), 1);
    checkOutput("over_score_r", int'(score_r), 9);
    frozen_l = m.pl;
    frozen_r = m.pr;
    frameStep(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("over_freeze_l", int'(padl_y), frozen_l);
    checkOutput("over_freeze_r", int'(padr_y), frozen_r);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("restart_state", int'(state), 0);
    checkOutput("restart_score_r", int'(score_r), 0);
    checkOutput("restart_flag", int'(game_over), 0);

    for (int f = 0; f < 3000; f++) begin
      lu = 1'($urandom_range(0, 1)); ld = 1'($urandom_range(0, 1));
      ru = 1'($urandom_range(0, 1)); rd = 1'($urandom_range(0, 1));
      applyStimulus(1'b1, ($urandom_range(0, 99) == 0), lu, ld, ru, rd);
      for (int g = 0; g < int'($urandom_range(1, 3)); g++)
        applyStimulus(1'b0, ($urandom_range(0, 99) == 0), lu, ld, ru, rd);
      if (f == 1500) asyncReset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
